cache: RTL and testbench

Two-way set-associative, write-back, write-allocate cache between the CPU datapath's 16-bit memory port and the 128-bit-line physical memory. It turns word and byte accesses into line-granularity memory transactions, with true-LRU replacement per set. Hits complete in one cycle. Misses issue at most one writeback followed by one line fill on the pmem port.

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_array.sv | 34 +++
 rtl/cache.sv | 154 +++++++++++++++
 tb/tb_cache.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, typedefs and FSM encoding for the two-way write-back cache.
package cache_types;
  localparam int TAG_W    = 9;
  localparam int IDX_W    = 3;
  localparam int WORD_W   = 3;
  localparam int LINE_W   = 128;
  localparam int NUM_SETS = 8;
  localparam int NUM_WAYS = 2;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {S_HIT, S_WRITEBACK, S_ALLOCATE} cache_state_t;
endpackage

// File: rtl/cache_array.sv
// Per-set storage column: synchronous write, asynchronous read, optional reset.
module cache_array
  import cache_types::*;
#(
  parameter int WIDTH      = 1,
  parameter bit RESETTABLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  idx_t             index,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout
);
  logic [WIDTH-1:0] mem [NUM_SETS];

  generate
    if (RESETTABLE) begin : g_rst
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < NUM_SETS; i++) mem[i] <= '0;
        end else if (load) begin
          mem[index] <= datain;
        end
      end
    end else begin : g_norst
      always_ff @(posedge clk) begin
        if (load) mem[index] <= datain;
      end
    end
  endgenerate

  assign dataout = mem[index];
endmodule

// File: rtl/cache.sv
// Two-way set-associative write-back/write-allocate cache, true-LRU, 16-bit CPU
// port over a 128-bit line memory port.
module cache
  import cache_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output line_t       pmem_wdata,
  input  line_t       pmem_rdata,
  input  logic        pmem_resp
);
  cache_state_t state, next_state;

  tag_t              req_tag;
  idx_t              req_idx;
  logic [WORD_W-1:0] req_word;
  logic              req, addr_unused;
  assign req_tag     = mem_address[15:7];
  assign req_idx     = mem_address[6:4];
  assign req_word    = mem_address[3:1];
  assign addr_unused = mem_address[0];
  assign req         = mem_read | mem_write;

  // Miss target is latched so the fill lands correctly even if the request drops.
  tag_t miss_tag;
  idx_t miss_idx;
  logic miss_way, capture;

  idx_t idx;
  assign idx = (state == S_HIT) ? req_idx : miss_idx;

  logic  [NUM_WAYS-1:0] valid_out, dirty_out, hit;
  tag_t  [NUM_WAYS-1:0] tag_out;
  line_t [NUM_WAYS-1:0] data_out;
  logic  [NUM_WAYS-1:0] valid_ld, dirty_ld, tag_ld, data_ld;
  logic                 dirty_in, lru_out, lru_ld, lru_in;
  line_t                data_in, merged;

  generate
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      cache_array #(.WIDTH(1)) u_valid (
        .clk(clk), .reset(reset), .load(valid_ld[w]), .index(idx),
        .datain(1'b1), .dataout(valid_out[w]));
      cache_array #(.WIDTH(1)) u_dirty (
        .clk(clk), .reset(reset), .load(dirty_ld[w]), .index(idx),
        .datain(dirty_in), .dataout(dirty_out[w]));
      cache_array #(.WIDTH(TAG_W)) u_tag (
        .clk(clk), .reset(reset), .load(tag_ld[w]), .index(idx),
        .datain(miss_tag), .dataout(tag_out[w]));
      cache_array #(.WIDTH(LINE_W), .RESETTABLE(1'b0)) u_data (
        .clk(clk), .reset(reset), .load(data_ld[w]), .index(idx),
        .datain(data_in), .dataout(data_out[w]));
      assign hit[w] = valid_out[w] && (tag_out[w] == req_tag);
    end
  endgenerate

  cache_array #(.WIDTH(1)) u_lru (
    .clk(clk), .reset(reset), .load(lru_ld), .index(idx),
    .datain(lru_in), .dataout(lru_out));

  logic hit_any, hit_way, victim;
  assign hit_any = |hit;
  assign hit_way = hit[1];
  assign victim  = !valid_out[0] ? 1'b0 : (!valid_out[1] ? 1'b1 : lru_out);

  always_comb begin
    merged = data_out[hit_way];
    if (mem_byte_enable[0]) merged[{req_word, 4'h0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged[{req_word, 4'h8} +: 8] = mem_wdata[15:8];
  end

  assign mem_rdata  = data_out[hit_way][{req_word, 4'h0} +: 16];
  assign pmem_wdata = data_out[miss_way];

  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    valid_ld     = '0;
    dirty_ld     = '0;
    tag_ld       = '0;
    data_ld      = '0;
    dirty_in     = 1'b0;
    data_in      = pmem_rdata;
    lru_ld       = 1'b0;
    lru_in       = ~hit_way;
    capture      = 1'b0;
    case (state)
      S_HIT: begin
        if (req && hit_any) begin
          mem_resp = 1'b1;
          lru_ld   = 1'b1;
          if (mem_write) begin
            data_ld[hit_way]  = 1'b1;
            dirty_ld[hit_way] = 1'b1;
            dirty_in          = 1'b1;
            data_in           = merged;
          end
        end else if (req) begin
          capture    = 1'b1;
          next_state = (valid_out[victim] && dirty_out[victim]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_out[miss_way], miss_idx, 4'h0};
        if (pmem_resp) begin
          dirty_ld[miss_way] = 1'b1;
          next_state         = req ? S_ALLOCATE : S_HIT;
        end
      end
      S_ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag, miss_idx, 4'h0};
        if (pmem_resp) begin
          valid_ld[miss_way] = 1'b1;
          dirty_ld[miss_way] = 1'b1;
          tag_ld[miss_way]   = 1'b1;
          data_ld[miss_way]  = 1'b1;
          next_state         = S_HIT;
        end
      end
      default: next_state = S_HIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_HIT;
      miss_tag <= '0;
      miss_idx <= '0;
      miss_way <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) begin
        miss_tag <= req_tag;
        miss_idx <= req_idx;
        miss_way <= victim;
      end
    end
  end
endmodule

// File: tb/tb_cache.sv
// Self-checking bench: set-level behavioural cache model plus a randomised-latency
// line memory, directed scenarios then random traffic.
module tb_cache;
  import cache_types::*;

  logic         clk = 1'b0, reset = 1'b1;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]   mem_byte_enable = '0;
  logic [15:0]  mem_address = '0, mem_wdata = '0;
  logic [15:0]  mem_rdata;
  logic         mem_resp, pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  cache dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp));

  always #5 clk = ~clk;

  localparam logic [127:0] LINE6        = 128'h7777_6666_5555_4444_3333_1234_5678_0000;
  localparam logic [127:0] LINE6_MERGED = 128'h7777_6666_5555_4444_3333_12EF_5678_0000;

  int tests = 0, fails = 0;
  int cyc = 0, last_resp_cyc = 0;
  bit mem_auto = 1'b1, rsp_wr;

  typedef struct {bit wr; logic [15:0] addr; logic [127:0] data;} txn_t;
  txn_t log_q[$];

  // physical memory as the responder sees it, and the model's own copy of it
  logic [127:0] phys [4096];
  logic [127:0] ref_mem [4096];

  logic         m_valid [8][2];
  logic         m_dirty [8][2];
  logic [8:0]   m_tag   [8][2];
  logic [127:0] m_data  [8][2];
  logic         m_lru   [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endfunction

  // line memory with 0-3 cycles of extra latency
  always begin
    @(negedge clk);
    if (mem_auto && !reset && (pmem_read || pmem_write)) begin
      rsp_wr = pmem_write;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (rsp_wr) begin
        phys[pmem_address[15:4]] = pmem_wdata;
        log_q.push_back('{wr: 1'b1, addr: pmem_address, data: pmem_wdata});
      end else begin
        pmem_rdata = phys[pmem_address[15:4]];
        log_q.push_back('{wr: 1'b0, addr: pmem_address, data: '0});
      end
      pmem_resp     = 1'b1;
      last_resp_cyc = cyc;
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      check("strobe_drop", rsp_wr ? pmem_write : pmem_read, 1'b0);
    end
  end

  // cycle-by-cycle bus sanity
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      tests++;
      if ((pmem_read && pmem_write) ||
          ((pmem_read || pmem_write) && pmem_address[3:0] != 4'h0) ||
          (mem_resp && !(mem_read || mem_write))) begin
        fails++;
        $display("FAIL bus_sane: rd=%b wr=%b addr=%h resp=%b req=%b", pmem_read,
                 pmem_write, pmem_address, mem_resp, mem_read | mem_write);
      end
    end
  end

  // rw: 0 = read, 1 = write, 2 = read+write (behaves as write)
  task automatic access(input int rw, input logic [15:0] a, input logic [1:0] be,
                        input logic [15:0] wd, output logic [15:0] rd, output int lat);
    int idx, w, v, n, wo;
    logic [8:0] t;
    bit hit, exp_wb;
    logic [15:0] wb_addr, fill_addr, exp_rd;
    logic [127:0] wb_data;
    idx = int'(a[6:4]); t = a[15:7]; wo = int'(a[3:1]);
    w = -1; v = 0; exp_wb = 1'b0; wb_addr = '0; wb_data = '0; fill_addr = '0;
    for (int i = 0; i < 2; i++) if (m_valid[idx][i] && m_tag[idx][i] == t) w = i;
    hit = (w >= 0);
    if (!hit) begin
      v = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : int'(m_lru[idx]));
      if (m_valid[idx][v] && m_dirty[idx][v]) begin
        exp_wb  = 1'b1;
        wb_addr = {m_tag[idx][v], a[6:4], 4'h0};
        wb_data = m_data[idx][v];
        ref_mem[wb_addr[15:4]] = wb_data;
      end
      fill_addr     = {t, a[6:4], 4'h0};
      m_data[idx][v]  = ref_mem[fill_addr[15:4]];
      m_tag[idx][v]   = t;
      m_valid[idx][v] = 1'b1;
      m_dirty[idx][v] = 1'b0;
      w = v;
    end
    if (rw != 0) begin
      if (be[0]) m_data[idx][w][16*wo +: 8]   = wd[7:0];
      if (be[1]) m_data[idx][w][16*wo+8 +: 8] = wd[15:8];
      m_dirty[idx][w] = 1'b1;
    end
    exp_rd = m_data[idx][w][16*wo +: 16];
    m_lru[idx] = (w == 0);

    log_q.delete();
    @(negedge clk);
    mem_read = (rw != 1); mem_write = (rw != 0);
    mem_address = a; mem_byte_enable = be; mem_wdata = wd;
    #1;
    lat = 0;
    while (!mem_resp && lat < 200) begin
      @(negedge clk);
      #1;
      lat++;
    end
    rd = mem_rdata;
    check("resp", mem_resp, 1'b1);
    if (rw == 0) check("rdata", mem_rdata, exp_rd);
    if (hit) begin
      check("hit_lat", lat, 0);
      check("hit_no_pmem", log_q.size(), 0);
    end else begin
      n = exp_wb ? 2 : 1;
      check("miss_txn_cnt", log_q.size(), n);
      if (log_q.size() == n) begin
        if (exp_wb) begin
          check("wb_addr", {log_q[0].wr, log_q[0].addr}, {1'b1, wb_addr});
          check("wb_data", log_q[0].data, wb_data);
        end
        check("fill_addr", {log_q[n-1].wr, log_q[n-1].addr}, {1'b0, fill_addr});
      end
      check("miss_resp_lat", cyc, last_resp_cyc + 1);
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_outputs", {mem_resp, pmem_read, pmem_write}, 3'b000);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] rd;
    int lat;
    for (int i = 0; i < 4096; i++) begin
      phys[i]    = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = phys[i];
    end
    phys[6] = LINE6; ref_mem[6] = LINE6;
    repeat (2) @(posedge clk);
    do_reset();

    // cold read, re-hit, byte write, dirty eviction
    access(0, 16'h0062, 2'b00, 16'h0000, rd, lat);
    if (log_q.size() == 1) check("t1_fill_addr", log_q[0].addr, 16'h0060);
    check("t1_rdata", rd, 16'h5678);
    access(0, 16'h0062, 2'b00, 16'h0000, rd, lat);
    check("t1_rehit_lat", lat, 0);
    access(1, 16'h0064, 2'b01, 16'hBEEF, rd, lat);
    access(0, 16'h0064, 2'b00, 16'h0000, rd, lat);
    check("t2_merge", rd, 16'h12EF);
    access(0, 16'h00E4, 2'b00, 16'h0000, rd, lat);
    access(0, 16'h0164, 2'b00, 16'h0000, rd, lat);
    check("t4_txns", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t4_wb", {log_q[0].wr, log_q[0].addr}, {1'b1, 16'h0060});
      check("t4_wb_line", log_q[0].data, LINE6_MERGED);
      check("t4_fill", {log_q[1].wr, log_q[1].addr}, {1'b0, 16'h0160});
    end

    // clean LRU eviction in set 6
    do_reset();
    access(0, 16'h0060, 2'b00, 16'h0000, rd, lat);
    access(0, 16'h00E0, 2'b00, 16'h0000, rd, lat);
    access(0, 16'h0160, 2'b00, 16'h0000, rd, lat);
    check("t3_clean_evict", {log_q.size() == 1, log_q.size() > 0 && log_q[0].wr}, 2'b10);
    access(0, 16'h00E0, 2'b00, 16'h0000, rd, lat);
    check("t3_keep_mru", lat, 0);
    access(0, 16'h0060, 2'b00, 16'h0000, rd, lat);
    check("t3_evicted", lat != 0, 1'b1);

    // read+write together on a hit line acts as a dirtying write
    access(2, 16'h00E2, 2'b11, 16'hCAFE, rd, lat);
    check("t6_both_hit", lat, 0);
    access(0, 16'h00E2, 2'b00, 16'h0000, rd, lat);
    check("t6_readback", rd, 16'hCAFE);
    access(0, 16'h0160, 2'b00, 16'h0000, rd, lat);
    access(0, 16'h0260, 2'b00, 16'h0000, rd, lat);
    if (log_q.size() == 2) check("t6_dirty_wb", {log_q[0].wr, log_q[0].addr}, {1'b1, 16'h00E0});
    else check("t6_dirty_wb_cnt", log_q.size(), 2);

    // reset while a fill is outstanding, then a stale pmem_resp
    do_reset();
    mem_auto = 1'b0;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h0362;
    #1;
    lat = 0;
    while (!pmem_read && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("t5_alloc", {pmem_read, pmem_address}, {1'b1, 16'h0360});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("t5_rst_drop", {pmem_read, pmem_write, mem_resp}, 3'b000);
    reset = 1'b0; mem_read = 1'b0;
    model_reset();
    @(negedge clk);
    pmem_rdata = '1; pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    check("t5_late_resp", {pmem_read, pmem_write, mem_resp}, 3'b000);
    mem_auto = 1'b1;
    access(0, 16'h0362, 2'b00, 16'h0000, rd, lat);
    check("t5_refetch", log_q.size(), 1);

    // random traffic over a few conflicting tags per set
    for (int k = 0; k < 300; k++) begin
      logic [15:0] a;
      a = {9'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0};
      access($urandom_range(0, 2), a, 2'($urandom_range(0, 3)), 16'($urandom), rd, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
